// File: rtl/irq_ctrl_pkg.sv
// Shared register map and field positions for the irq_ctrl block.
// Both the bus decoder and the priority encoder use these definitions.
package irq_ctrl_pkg;

   localparam logic [3:0] OFS_PENDING = 4'h0;
   localparam logic [3:0] OFS_MASK    = 4'h4;
   localparam logic [3:0] OFS_ID      = 4'h8;
   localparam logic [3:0] OFS_CTRL    = 4'hC;

   localparam logic [7:0] ID_NONE = 8'hFF;

   localparam int CTRL_GEN = 0;
   localparam int CTRL_OVR = 1;

   typedef enum logic [1:0] {
      REG_PENDING,
      REG_MASK,
      REG_ID,
      REG_CTRL
   } reg_sel_e;

   // Only meaningful for word-aligned offsets inside the 16-byte window.
   function automatic reg_sel_e ofs_to_sel(input logic [3:0] ofs);
      case (ofs)
         OFS_PENDING: return REG_PENDING;
         OFS_MASK:    return REG_MASK;
         OFS_ID:      return REG_ID;
         default:     return REG_CTRL;
      endcase
   endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-wins priority encoder over the active interrupt vector.
// Reports ID_NONE and any=0 when nothing is active.
module irq_prio_enc
   import irq_ctrl_pkg::*;
#(
   parameter int NSRC = 8
) (
   input  logic [NSRC-1:0] active,
   output logic [7:0]      id,
   output logic            any
);

   // Scanning downward lets the lowest set bit overwrite the higher ones.
   always_comb begin
      id = ID_NONE;
      for (int i = NSRC - 1; i >= 0; i--) begin
         if (active[i]) id = 8'(i);
      end
   end

   assign any = |active;

endmodule

// File: rtl/irq_ctrl.sv
// Memory-mapped interrupt controller on the native picorv32 bus: sticky pending
// bits from edge-detected events, per-source mask, global enable, overrun flag.
module irq_ctrl
   import irq_ctrl_pkg::*;
#(
   parameter logic [31:0] ADDR = 32'h0000_0000,
   parameter int          NSRC = 8
) (
   input  logic            clk,
   input  logic            resetn,
   input  logic [NSRC-1:0] irq_src,
   input  logic [31:0]     addr,
   input  logic            wen,
   input  logic [31:0]     wdata,
   input  logic            mem_valid,
   input  logic            mem_ready,
   output logic [31:0]     irq_rdata,
   output logic            irq_ready,
   output logic            irq_out
);

   logic [NSRC-1:0] r_src_prev;
   logic [NSRC-1:0] r_pending;
   logic [NSRC-1:0] r_mask;
   logic            r_gen;
   logic            r_ovr;
   logic            r_ready;
   logic [31:0]     r_rdata;
   logic            r_irq;

   logic [31:0]     w_ofs;
   logic            w_hit;
   reg_sel_e        w_sel;
   logic            w_req;
   logic            w_wr;
   logic [NSRC-1:0] w_event;
   logic [NSRC-1:0] w_pend_clr;
   logic [NSRC-1:0] w_pend_nxt;
   logic [NSRC-1:0] w_active;
   logic            w_ovr_set;
   logic            w_ovr_clr;
   logic [7:0]      w_id;
   logic            w_any;
   logic [31:0]     w_rd_mux;
   logic            w_unused_wdata;

   // Window of four aligned words starting at ADDR.
   assign w_ofs = addr - ADDR;
   assign w_hit = (w_ofs[31:4] == 28'd0) && (w_ofs[1:0] == 2'd0);
   assign w_sel = ofs_to_sel(w_ofs[3:0]);

   // mem_ready already carries our own ack, so the beat after it is refused;
   // r_ready covers the case where the CPU side does not echo it.
   assign w_req = mem_valid && w_hit && !mem_ready && !r_ready;
   assign w_wr  = w_req && wen;

   assign w_event    = irq_src & ~r_src_prev;
   assign w_pend_clr = (w_wr && (w_sel == REG_PENDING)) ? wdata[NSRC-1:0] : '0;
   // Set after clear: an event colliding with its own W1C keeps the bit.
   assign w_pend_nxt = (r_pending & ~w_pend_clr) | w_event;
   assign w_ovr_set  = |(w_event & r_pending & ~w_pend_clr);
   assign w_ovr_clr  = w_wr && (w_sel == REG_CTRL) && wdata[CTRL_OVR];
   assign w_active   = r_pending & r_mask;

   assign w_unused_wdata = ^wdata;

   irq_prio_enc #(
      .NSRC (NSRC)
   ) u_prio (
      .active (w_active),
      .id     (w_id),
      .any    (w_any)
   );

   // Read data comes from pre-edge state, so a concurrent update is not visible.
   always_comb begin
      w_rd_mux = '0;
      case (w_sel)
         REG_PENDING: w_rd_mux[NSRC-1:0] = r_pending;
         REG_MASK:    w_rd_mux[NSRC-1:0] = r_mask;
         REG_ID:      w_rd_mux[7:0]      = w_id;
         REG_CTRL: begin
            w_rd_mux[CTRL_GEN] = r_gen;
            w_rd_mux[CTRL_OVR] = r_ovr;
         end
         default:     w_rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_src_prev <= '0;
         r_pending  <= '0;
         r_mask     <= '0;
         r_gen      <= 1'b0;
         r_ovr      <= 1'b0;
         r_ready    <= 1'b0;
         r_rdata    <= '0;
         r_irq      <= 1'b0;
      end else begin
         r_src_prev <= irq_src;
         r_pending  <= w_pend_nxt;
         r_ovr      <= w_ovr_set | (r_ovr & ~w_ovr_clr);
         if (w_wr && (w_sel == REG_MASK)) r_mask <= wdata[NSRC-1:0];
         if (w_wr && (w_sel == REG_CTRL)) r_gen  <= wdata[CTRL_GEN];
         r_ready <= w_req;
         if (w_req) r_rdata <= w_rd_mux;
         r_irq <= r_gen & w_any;
      end
   end

   assign irq_rdata = r_rdata;
   assign irq_ready = r_ready;
   assign irq_out   = r_irq;

endmodule
